// File: rtl/width_trans_pkg.sv
// Shared widths and sizing helper for the width-translation write path.
package width_trans_pkg;

  localparam int unsigned DEF_IN_SIZE     = 3;
  localparam int unsigned DEF_WRDATA_SIZE = 4;
  localparam int unsigned DEF_ADDR_SIZE   = 4;

  // Number of bits needed to encode values 0..v-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/width_pack_wr.sv
// width_pack_wr: packs an IN_SIZE-bit input stream (LSB first) into
// WRDATA_SIZE-bit RAM write words at incrementing, wrapping addresses.
// Optional feature macro: WIDTH_PACK_FLUSH_EN adds flush / flush_done.
module width_pack_wr
  import width_trans_pkg::*;
#(
  parameter int unsigned IN_SIZE     = DEF_IN_SIZE,
  parameter int unsigned WRDATA_SIZE = DEF_WRDATA_SIZE,
  parameter int unsigned ADDR_SIZE   = DEF_ADDR_SIZE
) (
  input  logic                   wrclk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_SIZE-1:0]     in_data,
  input  logic                   stall,
`ifdef WIDTH_PACK_FLUSH_EN
  input  logic                   flush,
  output logic                   flush_done,
`endif
  output logic                   wren,
  output logic [ADDR_SIZE-1:0]   waddr,
  output logic [WRDATA_SIZE-1:0] wdata
);

  localparam int unsigned BUF = IN_SIZE + WRDATA_SIZE;
  localparam int unsigned CW  = clog2(BUF + 1);

  localparam logic [CW-1:0] WR_C  = CW'(WRDATA_SIZE);
  localparam logic [CW-1:0] IN_C  = CW'(IN_SIZE);
  localparam logic [CW:0]   IN_C1 = (CW+1)'(IN_SIZE);
  localparam logic [CW:0]   BUF_C = (CW+1)'(BUF);

  logic [BUF-1:0]         acc_q, acc_d, acc_sh;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_sh;
  logic [ADDR_SIZE-1:0]   wptr_q, wptr_d;
  logic [ADDR_SIZE-1:0]   waddr_q, waddr_d;
  logic [WRDATA_SIZE-1:0] wdata_q, wdata_d;
  logic                   wren_q, wren_d;
  logic                   drain, xfer, wr_fire, room;
  logic                   fl_wr, fl_block;

`ifdef WIDTH_PACK_FLUSH_EN
  logic pend_q, pend_d, done_q, done_d;

  // Flush bookkeeping: a partial word (0 < cnt < WRDATA_SIZE) is written
  // zero-padded; full words are left to the normal drain path first.
  always_comb begin
    fl_wr    = pend_q && !stall && (cnt_q != '0) && (cnt_q < WR_C);
    fl_block = pend_q;
    done_d   = pend_q && ((cnt_q == '0) || fl_wr);
    pend_d   = (pend_q && !done_d) || flush;
  end

  // Flush pending flag and done pulse.
  always_ff @(posedge wrclk) begin
    if (rst) begin
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      done_q <= done_d;
    end
  end

  assign flush_done = done_q;
`else
  assign fl_wr    = 1'b0;
  assign fl_block = 1'b0;
`endif

  // Drain/accept decision and next accumulator, counter and write port state.
  always_comb begin
    drain    = (cnt_q >= WR_C) && !stall;
    cnt_sh   = drain ? (cnt_q - WR_C) : cnt_q;
    acc_sh   = drain ? (acc_q >> WRDATA_SIZE) : acc_q;
    room     = ({1'b0, cnt_sh} + IN_C1) <= BUF_C;
    in_ready = room && !fl_block;
    xfer     = in_valid && in_ready;

    acc_d = acc_sh;
    cnt_d = cnt_sh;
    if (fl_wr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (xfer) begin
      // Bits above cnt are kept zero, so OR-ing the new word in is safe.
      acc_d = acc_sh | (BUF'(in_data) << cnt_sh);
      cnt_d = cnt_sh + IN_C;
    end

    wr_fire = drain || fl_wr;
    wren_d  = wr_fire;
    wdata_d = wr_fire ? acc_q[WRDATA_SIZE-1:0] : wdata_q;
    waddr_d = wr_fire ? wptr_q : waddr_q;
    wptr_d  = wr_fire ? (wptr_q + 1'b1) : wptr_q;
  end

  // State and registered RAM write port.
  always_ff @(posedge wrclk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
    end
  end

  assign wren  = wren_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_width_pack_wr.sv
// Directed bench for width_pack_wr with default widths (3 -> 4, 16 deep).
// With WIDTH_PACK_FLUSH_EN defined, the flush sequences are also exercised.
module tb_width_pack_wr;

  logic       wrclk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_data = '0;
  logic       stall = 1'b0;
  logic       wren;
  logic [3:0] waddr;
  logic [3:0] wdata;
`ifdef WIDTH_PACK_FLUSH_EN
  logic       flush = 1'b0;
  logic       flush_done;
`endif

  width_pack_wr #(.IN_SIZE(3), .WRDATA_SIZE(4), .ADDR_SIZE(4)) dut (
    .wrclk(wrclk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .stall(stall),
`ifdef WIDTH_PACK_FLUSH_EN
    .flush(flush),
    .flush_done(flush_done),
`endif
    .wren(wren),
    .waddr(waddr),
    .wdata(wdata)
  );

  always #5 wrclk = ~wrclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       vld;
    logic [2:0] data;
    logic       stall;
    logic       chk_rdy;
    logic       rdy;
    logic       wren;
    logic [3:0] waddr;
    logic [3:0] wdata;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  logic [2:0] words [48];
  logic       bq [$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int i, nwr;
    logic rdy_s;
    logic [3:0] expw;

    //             rst vld data   stl chkr rdy wren addr  data
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 1'b1, 3'b110, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'hD};
    tbl[4]  = '{1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 4'h9};
    tbl[5]  = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 4'h3};
    tbl[6]  = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 4'h3};
    tbl[7]  = '{1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 4'h3};
    tbl[8]  = '{1'b0, 1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 4'h3};
    tbl[9]  = '{1'b0, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 4'h3};
    tbl[10] = '{1'b0, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 4'h3};
    tbl[11] = '{1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 4'h7};
    tbl[12] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 4'h4, 4'h1};
    tbl[13] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h4, 4'h1};
    tbl[14] = '{1'b0, 1'b1, 3'b110, 1'b1, 1'b1, 1'b1, 1'b0, 4'h4, 4'h1};
    tbl[15] = '{1'b1, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
    tbl[16] = '{1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[17] = '{1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[18] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h3};
    tbl[19] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h3};

    for (int k = 0; k < NV; k++) begin
      @(negedge wrclk);
      rst      = tbl[k].rst;
      in_valid = tbl[k].vld;
      in_data  = tbl[k].data;
      stall    = tbl[k].stall;
      #1;
      if (tbl[k].chk_rdy) chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(tbl[k].rdy));
      @(posedge wrclk);
      #1;
      chk($sformatf("v%0d wren", k), 32'(wren), 32'(tbl[k].wren));
      chk($sformatf("v%0d waddr", k), 32'(waddr), 32'(tbl[k].waddr));
      chk($sformatf("v%0d wdata", k), 32'(wdata), 32'(tbl[k].wdata));
    end

    // Continuous stream of 48 words: 144 bits -> 36 writes, address wraps twice.
    @(negedge wrclk);
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0;
    @(negedge wrclk);
    rst = 1'b0;
    for (int k = 0; k < 48; k++) words[k] = 3'($urandom_range(0, 7));
    i = 0;
    nwr = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge wrclk);
      in_valid = (i < 48);
      in_data  = (i < 48) ? words[i] : 3'b000;
      #1;
      rdy_s = in_ready;
      @(posedge wrclk);
      if (in_valid && rdy_s) begin
        for (int b = 0; b < 3; b++) bq.push_back(words[i][b]);
        i++;
      end
      #1;
      if (wren) begin
        if (bq.size() < 4) begin
          chk($sformatf("stream w%0d bits available", nwr), 32'(bq.size()), 32'd4);
          expw = 'x;
        end else begin
          for (int b = 0; b < 4; b++) expw[b] = bq.pop_front();
          chk($sformatf("stream w%0d wdata", nwr), 32'(wdata), 32'(expw));
        end
        chk($sformatf("stream w%0d waddr", nwr), 32'(waddr), 32'(nwr % 16));
        nwr++;
      end
      if (i == 48 && nwr >= 36 && c > 60) break;
    end
    chk("stream words accepted", 32'(i), 32'd48);
    chk("stream write count", 32'(nwr), 32'd36);

`ifdef WIDTH_PACK_FLUSH_EN
    @(negedge wrclk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge wrclk);
    rst = 1'b0; in_valid = 1'b1; in_data = 3'b101;
    @(posedge wrclk); #1;
    chk("fl accept wren", 32'(wren), 32'd0);
    @(negedge wrclk);
    in_valid = 1'b0; flush = 1'b1;
    @(posedge wrclk); #1;
    chk("fl req done", 32'(flush_done), 32'd0);
    @(negedge wrclk);
    flush = 1'b0;
    #1;
    chk("fl pend in_ready", 32'(in_ready), 32'd0);
    @(posedge wrclk); #1;
    chk("fl write wren", 32'(wren), 32'd1);
    chk("fl write wdata", 32'(wdata), 32'h5);
    chk("fl write waddr", 32'(waddr), 32'h0);
    chk("fl write done", 32'(flush_done), 32'd1);
    @(negedge wrclk); #1;
    chk("fl after in_ready", 32'(in_ready), 32'd1);
    @(posedge wrclk); #1;
    chk("fl after done", 32'(flush_done), 32'd0);
    chk("fl after wren", 32'(wren), 32'd0);
    @(negedge wrclk);
    flush = 1'b1;
    @(posedge wrclk); #1;
    chk("fl0 req done", 32'(flush_done), 32'd0);
    @(negedge wrclk);
    flush = 1'b0;
    @(posedge wrclk); #1;
    chk("fl0 done", 32'(flush_done), 32'd1);
    chk("fl0 wren", 32'(wren), 32'd0);
    @(posedge wrclk); #1;
    chk("fl0 done clear", 32'(flush_done), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
